// File: rtl/alu_pkg.sv
// Shared definitions for the two-requester ALU arbiter: opcodes, FSM encoding,
// and the default datapath width.
package alu_pkg;

    localparam int WIDTH_DEF = 40;

    localparam logic [4:0] OP_ADD = 5'b00101;
    localparam logic [4:0] OP_SUB = 5'b00110;
    localparam logic [4:0] OP_MUL = 5'b01000;
    localparam logic [4:0] OP_DIV = 5'b01011;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_e;

endpackage

// File: rtl/alu_core.sv
// Registered unsigned arithmetic unit: result and error flag load when en_i is
// high and otherwise hold, so the arbiter's response fields stay stable.
module alu_core
    import alu_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en_i,
    input  logic [4:0]       op_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic [WIDTH-1:0] data_o,
    output logic             err_o
);

    logic [WIDTH-1:0] data_d, data_q;
    logic             err_d, err_q;

    always_comb begin
        data_d = '0;
        err_d  = 1'b0;
        case (op_i)
            OP_ADD: data_d = a_i + b_i;
            OP_SUB: data_d = a_i - b_i;
            OP_MUL: data_d = a_i * b_i;
            OP_DIV: begin
                // Divide by zero saturates to all ones rather than leaving X.
                if (b_i == '0) begin
                    data_d = '1;
                    err_d  = 1'b1;
                end else begin
                    data_d = a_i / b_i;
                end
            end
            default: err_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q <= '0;
            err_q  <= 1'b0;
        end else if (en_i) begin
            data_q <= data_d;
            err_q  <= err_d;
        end
    end

    assign data_o = data_q;
    assign err_o  = err_q;

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin arbiter feeding a single one-cycle ALU; one transaction in flight,
// IDLE -> EXEC -> RESP, with the response held until the consumer takes it.
module alu_arbiter
    import alu_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [4:0]       req0_op,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [4:0]       req1_op,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
    output logic [WIDTH-1:0] rsp_data,
    output logic             rsp_err,
    output logic             busy
);

    state_e           state_q, state_d;
    logic             prio_q, prio_d;
    logic [4:0]       op_q, op_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
    logic             id_q, id_d;
    logic             rsp_id_q;
    logic             gnt_vld, gnt_id, accept, exec_en;

    // With both valid the pointer decides; otherwise the lone valid wins.
    assign gnt_vld = req0_valid | req1_valid;
    assign gnt_id  = (req0_valid && req1_valid) ? prio_q : req1_valid;
    assign accept  = (state_q == ST_IDLE) && gnt_vld;
    assign exec_en = (state_q == ST_EXEC);

    assign req0_ready = rst_n && accept && !gnt_id;
    assign req1_ready = rst_n && accept &&  gnt_id;

    always_comb begin
        state_d = state_q;
        prio_d  = prio_q;
        op_d    = op_q;
        a_d     = a_q;
        b_d     = b_q;
        id_d    = id_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d = ST_EXEC;
                    prio_d  = ~gnt_id;
                    id_d    = gnt_id;
                    op_d    = gnt_id ? req1_op : req0_op;
                    a_d     = gnt_id ? req1_a  : req0_a;
                    b_d     = gnt_id ? req1_b  : req0_b;
                end
            end
            ST_EXEC: state_d = ST_RESP;
            ST_RESP: if (rsp_ready) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            prio_q   <= 1'b0;
            op_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            id_q     <= 1'b0;
            rsp_id_q <= 1'b0;
        end else begin
            state_q <= state_d;
            prio_q  <= prio_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            id_q    <= id_d;
            // Response id moves with the ALU result so it holds outside RESP too.
            if (exec_en) rsp_id_q <= id_q;
        end
    end

    alu_core #(.WIDTH(WIDTH)) u_core (
        .clk   (clk),
        .rst_n (rst_n),
        .en_i  (exec_en),
        .op_i  (op_q),
        .a_i   (a_q),
        .b_i   (b_q),
        .data_o(rsp_data),
        .err_o (rsp_err)
    );

    assign rsp_valid = (state_q == ST_RESP);
    assign rsp_id    = rsp_id_q;
    assign busy      = (state_q != ST_IDLE);

endmodule
